// File: rtl/fetch_ctrl.sv
// Purpose: instruction-fetch sequencer. It drives nextPC/StallF, runs the imem request handshake,
//          parks a fetched word while decode is stalled, and applies exception/branch/jump redirects.
// Latency: 0 cycles with a zero-wait memory (InstrF is combinational from imem_rdata); a miss adds one cycle per imem wait cycle.
// Backpressure: StallD parks a returned word in the hold buffer with the PC held. StallF holds the PC while a request is outstanding.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'h00400020,
    parameter logic [31:0] EXC_VECTOR = 32'h80000180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] currPC,
    output logic [31:0] nextPC,
    output logic        StallF,
    input  logic        StallD,
    input  logic        PCSrcD,
    input  logic [31:0] PCBranchD,
    input  logic        JumpD,
    input  logic [31:0] PCJumpD,
    input  logic        ExcE,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] InstrF,
    output logic        InstrValidF,
    output logic        FlushD
);

    // Controller states
    localparam logic [2:0] S_RST   = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;

    // Redirect priority levels; a larger value wins
    localparam logic [1:0] PRI_NONE = 2'd0;
    localparam logic [1:0] PRI_JMP  = 2'd1;
    localparam logic [1:0] PRI_BR   = 2'd2;
    localparam logic [1:0] PRI_EXC  = 2'd3;

    logic [2:0]  state;
    logic [2:0]  state_nxt;
    logic [31:0] hold_dat;      // word parked while decode is stalled
    logic [31:0] hold_nxt;
    logic [31:0] tgt_q;         // redirect target waiting for a miss to drain
    logic [31:0] tgt_nxt;
    logic [1:0]  tgt_pri_q;     // priority of the latched target
    logic [1:0]  tgt_pri_nxt;
    logic [31:0] addr_q;        // address of the outstanding request
    logic [31:0] addr_nxt;

    logic [1:0]  redir_pri;
    logic [31:0] redir_tgt;
    logic        redir;
    logic [31:0] pc_plus4;

    assign pc_plus4 = currPC + 32'd4;
    assign redir    = (redir_pri != PRI_NONE);

    // Select the winning redirect. Decode-stage redirects are ignored while decode is stalled.
    always_comb begin
        redir_pri = PRI_NONE;
        redir_tgt = currPC;
        if (ExcE) begin
            redir_pri = PRI_EXC;
            redir_tgt = EXC_VECTOR;
        end else if (!StallD && PCSrcD) begin
            redir_pri = PRI_BR;
            redir_tgt = PCBranchD;
        end else if (!StallD && JumpD) begin
            redir_pri = PRI_JMP;
            redir_tgt = PCJumpD;
        end
    end

    // Next-state and output decode. Reset overrides everything combinationally, so a
    // response arriving in a reset cycle is never seen. The RST state behaves like FETCH
    // once reset drops, so the first fetch issues on the first cycle out of reset.
    always_comb begin
        state_nxt   = state;
        hold_nxt    = hold_dat;
        tgt_nxt     = tgt_q;
        tgt_pri_nxt = tgt_pri_q;
        addr_nxt    = addr_q;
        nextPC      = currPC;
        StallF      = 1'b1;
        FlushD      = 1'b0;
        imem_req    = 1'b0;
        imem_addr   = currPC;
        InstrF      = 32'd0;
        InstrValidF = 1'b0;

        if (reset) begin
            nextPC      = RESET_PC;
            StallF      = 1'b0;
            FlushD      = 1'b1;
            state_nxt   = S_RST;
            hold_nxt    = 32'd0;
            tgt_nxt     = 32'd0;
            tgt_pri_nxt = PRI_NONE;
            addr_nxt    = 32'd0;
        end else begin
            case (state)
                S_RST, S_FETCH, S_WAIT: begin
                    imem_req  = 1'b1;
                    // While waiting, the PC is frozen; the registered address keeps the request stable regardless
                    imem_addr = (state == S_WAIT) ? addr_q : currPC;
                    addr_nxt  = imem_addr;
                    InstrF    = imem_rdata;
                    if (redir) begin
                        if (imem_ready) begin
                            // Word belongs to the wrong path: drop it and redirect now
                            nextPC    = redir_tgt;
                            StallF    = 1'b0;
                            FlushD    = 1'b1;
                            state_nxt = S_FETCH;
                        end else begin
                            // Request cannot be cancelled; remember where to go once it lands
                            tgt_nxt     = redir_tgt;
                            tgt_pri_nxt = redir_pri;
                            state_nxt   = S_DRAIN;
                        end
                    end else if (imem_ready && !StallD) begin
                        InstrValidF = 1'b1;
                        nextPC      = pc_plus4;
                        StallF      = 1'b0;
                        state_nxt   = S_FETCH;
                    end else if (imem_ready) begin
                        hold_nxt  = imem_rdata;
                        state_nxt = S_HOLD;
                    end else begin
                        state_nxt = S_WAIT;
                    end
                end

                S_HOLD: begin
                    InstrF = hold_dat;
                    if (redir) begin
                        // Parked word is wrong-path: discard it
                        nextPC    = redir_tgt;
                        StallF    = 1'b0;
                        FlushD    = 1'b1;
                        state_nxt = S_FETCH;
                    end else begin
                        InstrValidF = 1'b1;
                        if (!StallD) begin
                            nextPC    = pc_plus4;
                            StallF    = 1'b0;
                            state_nxt = S_FETCH;
                        end
                    end
                end

                S_DRAIN: begin
                    imem_req  = 1'b1;
                    imem_addr = addr_q;
                    // A newer redirect of equal or higher priority supersedes the latched one
                    if (redir && (redir_pri >= tgt_pri_q)) begin
                        tgt_nxt     = redir_tgt;
                        tgt_pri_nxt = redir_pri;
                    end
                    if (imem_ready) begin
                        nextPC      = tgt_nxt;
                        StallF      = 1'b0;
                        FlushD      = 1'b1;
                        tgt_pri_nxt = PRI_NONE;
                        state_nxt   = S_FETCH;
                    end
                end

                default: begin
                    state_nxt = S_RST;
                end
            endcase
        end
    end

    // State, hold buffer, latched redirect target and outstanding address
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_RST;
            hold_dat  <= 32'd0;
            tgt_q     <= 32'd0;
            tgt_pri_q <= PRI_NONE;
            addr_q    <= 32'd0;
        end else begin
            state     <= state_nxt;
            hold_dat  <= hold_nxt;
            tgt_q     <= tgt_nxt;
            tgt_pri_q <= tgt_pri_nxt;
            addr_q    <= addr_nxt;
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Purpose: self-checking bench for fetch_ctrl with a PC register, a variable-latency memory and a reference model.
// Latency: one bench cycle per clock; inputs are driven just after posedge and outputs are sampled at negedge.
// Backpressure: StallD and the redirects are driven directly; memory latency is fixed per scenario or random.
module tb_fetch_ctrl;

    localparam logic [31:0] RESET_PC   = 32'h00400020;
    localparam logic [31:0] EXC_VECTOR = 32'h80000180;

    logic        clk;
    logic        reset;
    logic [31:0] currPC;
    logic [31:0] nextPC;
    logic        StallF;
    logic        StallD;
    logic        PCSrcD;
    logic [31:0] PCBranchD;
    logic        JumpD;
    logic [31:0] PCJumpD;
    logic        ExcE;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] InstrF;
    logic        InstrValidF;
    logic        FlushD;

    fetch_ctrl #(.RESET_PC(RESET_PC), .EXC_VECTOR(EXC_VECTOR)) dut (
        .clk(clk), .reset(reset), .currPC(currPC), .nextPC(nextPC), .StallF(StallF),
        .StallD(StallD), .PCSrcD(PCSrcD), .PCBranchD(PCBranchD), .JumpD(JumpD),
        .PCJumpD(PCJumpD), .ExcE(ExcE), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata), .InstrF(InstrF),
        .InstrValidF(InstrValidF), .FlushD(FlushD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Environment: PC register and memory responder
    logic [31:0] pc;
    int          fixed_delay;
    int          mem_delay;
    int          mem_wait;
    bit          force_rdy;
    bit          force_word_en;
    logic [31:0] force_word;

    // Reference model: parked word, pending redirect
    bit          m_buf_v, m_pend_v;
    logic [31:0] m_buf, m_pend_t;
    int          m_pend_p;

    // DUT outputs sampled in the most recent cycle
    logic [31:0] s_next, s_addr, s_instr;
    logic        s_stall, s_flush, s_valid, s_req;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        else
            n_pass++;
    endtask

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h13572468;
    endfunction

    task automatic set_delay(input int d);
        fixed_delay = d;
        mem_delay   = (d >= 0) ? d : 1;
    endtask

    task automatic idle_inputs();
        reset = 1'b0; StallD = 1'b0; PCSrcD = 1'b0; JumpD = 1'b0; ExcE = 1'b0;
        PCBranchD = 32'd0; PCJumpD = 32'd0;
        force_rdy = 1'b0; force_word_en = 1'b0;
    endtask

    // One clock: entered just after posedge with control inputs set; returns just after the next posedge
    task automatic cycle();
        int          pri;
        logic [31:0] tgt;
        logic [31:0] e_next, e_addr, e_instr;
        logic        e_stall, e_flush, e_valid, e_req;
        bit          n_buf_v, n_pend_v;
        logic [31:0] n_buf, n_pend_t;
        int          n_pend_p;

        currPC = pc;
        #1;
        if (force_rdy) begin
            imem_ready = 1'b1;
            mem_wait   = 0;
        end else if (imem_req) begin
            if (mem_wait >= mem_delay) begin
                imem_ready = 1'b1;
                mem_wait   = 0;
                mem_delay  = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 3));
            end else begin
                imem_ready = 1'b0;
                mem_wait++;
            end
        end else begin
            imem_ready = 1'b0;
            mem_wait   = 0;
        end
        imem_rdata = force_word_en ? force_word : word_of(imem_addr);

        // Reference behaviour for this cycle
        pri = 0; tgt = 32'd0;
        if (ExcE)                  begin pri = 3; tgt = EXC_VECTOR; end
        else if (!StallD && PCSrcD) begin pri = 2; tgt = PCBranchD; end
        else if (!StallD && JumpD)  begin pri = 1; tgt = PCJumpD; end
        n_buf_v = m_buf_v; n_buf = m_buf; n_pend_v = m_pend_v; n_pend_t = m_pend_t; n_pend_p = m_pend_p;
        e_req = 1'b0; e_addr = pc; e_next = pc; e_stall = 1'b1; e_flush = 1'b0; e_valid = 1'b0; e_instr = 32'd0;
        if (reset) begin
            e_next = RESET_PC; e_stall = 1'b0; e_flush = 1'b1;
            n_buf_v = 1'b0; n_pend_v = 1'b0;
        end else if (m_buf_v) begin
            e_instr = m_buf;
            if (pri > 0) begin
                e_next = tgt; e_stall = 1'b0; e_flush = 1'b1; n_buf_v = 1'b0;
            end else begin
                e_valid = 1'b1;
                if (!StallD) begin e_next = pc + 32'd4; e_stall = 1'b0; n_buf_v = 1'b0; end
            end
        end else if (m_pend_v) begin
            e_req = 1'b1;
            if (pri > 0 && pri >= m_pend_p) begin n_pend_t = tgt; n_pend_p = pri; end
            if (imem_ready) begin e_next = n_pend_t; e_stall = 1'b0; e_flush = 1'b1; n_pend_v = 1'b0; end
        end else begin
            e_req = 1'b1;
            if (pri > 0) begin
                if (imem_ready) begin e_next = tgt; e_stall = 1'b0; e_flush = 1'b1; end
                else begin n_pend_v = 1'b1; n_pend_t = tgt; n_pend_p = pri; end
            end else if (imem_ready && !StallD) begin
                e_valid = 1'b1; e_instr = imem_rdata; e_next = pc + 32'd4; e_stall = 1'b0;
            end else if (imem_ready) begin
                n_buf_v = 1'b1; n_buf = imem_rdata;
            end
        end

        @(negedge clk);
        check("imem_req", {31'd0, imem_req}, {31'd0, e_req});
        check("StallF", {31'd0, StallF}, {31'd0, e_stall});
        check("FlushD", {31'd0, FlushD}, {31'd0, e_flush});
        check("InstrValidF", {31'd0, InstrValidF}, {31'd0, e_valid});
        if (!e_stall) check("nextPC", nextPC, e_next);
        if (e_req) check("imem_addr", imem_addr, e_addr);
        if (e_valid || reset) check("InstrF", InstrF, e_instr);
        s_next = nextPC; s_addr = imem_addr; s_instr = InstrF;
        s_stall = StallF; s_flush = FlushD; s_valid = InstrValidF; s_req = imem_req;

        @(posedge clk);
        m_buf_v = n_buf_v; m_buf = n_buf; m_pend_v = n_pend_v; m_pend_t = n_pend_t; m_pend_p = n_pend_p;
        if (reset) pc = RESET_PC;
        else if (!e_stall) pc = e_next;
        #1;
    endtask

    task automatic do_reset(input int n);
        idle_inputs();
        reset = 1'b1;
        repeat (n) cycle();
        reset = 1'b0;
    endtask

    initial begin
        int acc;
        pc = RESET_PC; currPC = RESET_PC;
        imem_ready = 1'b0; imem_rdata = 32'd0;
        m_buf_v = 1'b0; m_pend_v = 1'b0; m_buf = 32'd0; m_pend_t = 32'd0; m_pend_p = 0;
        mem_wait = 0; force_word = 32'd0;
        set_delay(0);
        idle_inputs();
        #6;

        // Reset values, then zero-wait streaming
        reset = 1'b1;
        cycle();
        check("rst_stall", {31'd0, s_stall}, 32'd0);
        check("rst_flush", {31'd0, s_flush}, 32'd1);
        check("rst_req", {31'd0, s_req}, 32'd0);
        check("rst_next", s_next, RESET_PC);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("stream_pc", s_addr, RESET_PC + 32'(4 * i));
            check("stream_valid", {31'd0, s_valid}, 32'd1);
        end

        // Three-cycle miss
        do_reset(2);
        set_delay(3);
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("miss_stall", {31'd0, s_stall}, 32'd1);
            check("miss_addr", s_addr, 32'h00400020);
        end
        cycle();
        check("miss_done_next", s_next, 32'h00400024);

        // Decode stall while a word returns
        do_reset(2);
        set_delay(0);
        force_word_en = 1'b1; force_word = 32'h8C080004;
        acc = 0;
        StallD = 1'b1;
        cycle();
        check("hold_enter_stall", {31'd0, s_stall}, 32'd1);
        force_word_en = 1'b0;
        cycle();
        check("hold_instr", s_instr, 32'h8C080004);
        check("hold_stall", {31'd0, s_stall}, 32'd1);
        if (s_valid && !StallD) acc++;
        StallD = 1'b0;
        cycle();
        if (s_valid && !StallD) acc++;
        check("hold_release_instr", s_instr, 32'h8C080004);
        check("hold_release_next", s_next, 32'h00400024);
        check("hold_accept_once", 32'(acc), 32'd1);
        cycle();
        check("hold_after_addr", s_addr, 32'h00400024);

        // Branch during a miss
        do_reset(2);
        set_delay(2);
        PCSrcD = 1'b1; PCBranchD = 32'h00400100;
        cycle();
        check("drain_enter_flush", {31'd0, s_flush}, 32'd0);
        PCSrcD = 1'b0;
        cycle();
        check("drain_valid", {31'd0, s_valid}, 32'd0);
        cycle();
        check("drain_flush", {31'd0, s_flush}, 32'd1);
        check("drain_next", s_next, 32'h00400100);
        check("drain_drop", {31'd0, s_valid}, 32'd0);
        cycle();
        check("drain_after_addr", s_addr, 32'h00400100);

        // Exception beats jump; stalled branch ignored
        do_reset(2);
        set_delay(0);
        ExcE = 1'b1; JumpD = 1'b1; PCJumpD = 32'h00400200;
        cycle();
        check("exc_next", s_next, EXC_VECTOR);
        check("exc_flush", {31'd0, s_flush}, 32'd1);
        ExcE = 1'b0; JumpD = 1'b0;
        PCSrcD = 1'b1; PCBranchD = 32'h00400300; StallD = 1'b1;
        cycle();
        check("stalled_br_addr", s_addr, EXC_VECTOR);
        check("stalled_br_flush", {31'd0, s_flush}, 32'd0);
        PCSrcD = 1'b0; StallD = 1'b0;
        cycle();
        check("stalled_br_next", s_next, EXC_VECTOR + 32'd4);

        // Reset during a miss with a response in the reset cycle
        do_reset(2);
        set_delay(5);
        cycle();
        cycle();
        reset = 1'b1; force_rdy = 1'b1;
        cycle();
        check("midrst_valid", {31'd0, s_valid}, 32'd0);
        check("midrst_next", s_next, RESET_PC);
        reset = 1'b0; force_rdy = 1'b0;
        set_delay(0);
        cycle();
        check("midrst_restart", s_addr, RESET_PC);
        check("midrst_restart_valid", {31'd0, s_valid}, 32'd1);

        // Randomized traffic against the model
        set_delay(-1);
        for (int i = 0; i < 4000; i++) begin
            reset     = ($urandom_range(0, 199) == 0);
            StallD    = ($urandom_range(0, 2) == 0);
            PCSrcD    = ($urandom_range(0, 11) == 0);
            JumpD     = ($urandom_range(0, 11) == 0);
            ExcE      = ($urandom_range(0, 24) == 0);
            PCBranchD = $urandom() & 32'hFFFFFFFC;
            PCJumpD   = $urandom() & 32'hFFFFFFFC;
            force_rdy = reset && ($urandom_range(0, 1) == 0);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch controller for the five-stage MIPS pipeline. It sequences the PC register by computing `nextPC` and `StallF` each cycle. It handles a multi-cycle instruction-memory handshake and buffers the fetched word while decode is stalled. It applies branch, jump and exception redirects, squashing wrong-path fetches, and sits between the PC register, instruction memory, the hazard unit and the IF/ID register.

## Interface
- `RESET_PC`, 32'h00400020: PC value loaded on reset.
- `EXC_VECTOR`, 32'h80000180: redirect target on exception.

Ports:
- `clk`  in  1  single clock; all state changes on posedge.
- `reset`  in  1  synchronous, active-high.
- `currPC`  in  32  current PC from the PC register.
- `nextPC`  out  32  value the PC register loads when `StallF`=0.
- `StallF`  out  1  hold PC register.
- `StallD`  in  1  hazard unit: decode cannot accept a new instruction.
- `PCSrcD`  in  1  branch taken, resolved in decode.
- `PCBranchD`  in  32  branch target.
- `JumpD`  in  1  jump in decode.
- `PCJumpD`  in  32  jump target.
- `ExcE`  in  1  exception raised in execute.
- `imem_req`  out  1  fetch request; held with `imem_addr` until `imem_ready`.
- `imem_addr`  out  32  fetch address (= `currPC` when issued).
- `imem_ready`  in  1  one-cycle pulse; `imem_rdata` valid in this cycle.
- `imem_rdata`  in  32  fetched word.
- `InstrF`  out  32  instruction to IF/ID.
- `InstrValidF`  out  1  `InstrF` valid and accepted this cycle if `StallD`=0.
- `FlushD`  out  1  clear IF/ID register.

## Operation
- States: RST, FETCH, WAIT, HOLD, DRAIN.
- Redirect priority: `ExcE` > `PCSrcD` > `JumpD`. `PCSrcD` and `JumpD` are ignored while `StallD`=1; `ExcE` is never ignored. Target `T` is `EXC_VECTOR`, `PCBranchD` or `PCJumpD` respectively.
- RST (while `reset`=1):
  - Outputs: `nextPC`=`RESET_PC`, `StallF`=0, `FlushD`=1, `imem_req`=0, `InstrValidF`=0, `InstrF`=0.
  - Exit to FETCH on the first cycle with `reset`=0.
- FETCH: `imem_req`=1, `imem_addr`=`currPC`, `StallF`=1 unless advancing.
  - Redirect this cycle: drop any returned word; if `imem_ready`, set `nextPC`=`T`, `StallF`=0, `FlushD`=1, stay FETCH; else latch `T`, go DRAIN.
  - `imem_ready` and `StallD`=0: `InstrF`=`imem_rdata`, `InstrValidF`=1, `nextPC`=`currPC`+4 (mod 2^32), `StallF`=0, stay FETCH.
  - `imem_ready` and `StallD`=1: capture `imem_rdata` into hold buffer, go HOLD.
  - No `imem_ready`: go WAIT.
- WAIT: same as FETCH. The request stays asserted with the same address; `imem_ready` returns to FETCH behaviour.
- HOLD: `imem_req`=0, `InstrF`=buffer, `InstrValidF`=1, `StallF`=1.
  - When `StallD`=0: `nextPC`=`currPC`+4, `StallF`=0, go FETCH.
  - Redirect: discard buffer, `nextPC`=`T`, `StallF`=0, `FlushD`=1, go FETCH.
- DRAIN: an outstanding request cannot be cancelled.
  - `imem_req`=1 on the old address, `InstrValidF`=0, `StallF`=1.
  - A higher-or-equal-priority redirect overwrites the latched target.
  - On `imem_ready`: discard the word, `nextPC`=latched target, `StallF`=0, `FlushD`=1, go FETCH.
- `FlushD`=1 only in cycles where a redirect loads the PC, and during reset.
- `reset` mid-operation: return to RST at the next edge. Discard the hold buffer and latched target. A memory response arriving in RST is ignored.

## Timing
- Reset values: `StallF`=0, `nextPC`=`RESET_PC`, `FlushD`=1, `imem_req`=0, `InstrValidF`=0, `InstrF`=0.
- Zero-wait memory (`imem_ready` same cycle as request): one instruction per cycle, with `InstrF` combinational from `imem_rdata`.
- Redirect with no outstanding miss: the PC holds `T` at the next edge, giving one bubble.
- Redirect during a miss: the PC loads `T` at the edge after `imem_ready`.
- `nextPC`, `StallF`, `FlushD` and `InstrValidF` are combinational from state and inputs. State, hold buffer and latched target are registered.

## Test plan
- Reset, then zero-wait memory → `currPC` sequence 0x00400020, 0x00400024, 0x00400028; `InstrValidF`=1 each cycle.
- `imem_ready` delayed 3 cycles → `StallF`=1 for 3 cycles, `imem_addr` stable at 0x00400020; word delivered, PC advances to 0x00400024.
- `StallD`=1 for 2 cycles as word 0x8C080004 returns → HOLD presents 0x8C080004 with PC held; released, PC advances by 4 and the word is accepted exactly once.
- `PCSrcD`=1 with `PCBranchD`=0x00400100 during a 2-cycle miss → DRAIN; the returned word is dropped; `FlushD` pulses; next PC is 0x00400100.
- Same cycle `ExcE`=1, `JumpD`=1 (`PCJumpD`=0x00400200) → `nextPC`=0x80000180. `PCSrcD`=1 with `StallD`=1 → ignored.
- `reset` asserted in WAIT with a response arriving in the reset cycle → response ignored; after release, fetch restarts at 0x00400020.
